reorder_buffer_n: RTL and testbench

Clocked, parametrised reorder buffer for the out-of-order RISC-V core, between dispatch/rename and the functional-unit writeback buses.
Allocates DISP_W entries per cycle in program order, marks entries complete from WB_W tag-addressed writeback ports, and retires up to RET_W consecutive completed entries per cycle in order.

---
 rtl/reorder_buffer_n_pkg.sv | 40 ++++
 rtl/reorder_buffer_n_if.sv | 57 +++++
 rtl/reorder_buffer_n_rob_ptr.sv | 44 ++++
 rtl/reorder_buffer_n.sv | 195 +++++++++++++++++++
 tb/tb_reorder_buffer_n.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reorder_buffer_n_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_n_pkg
// Brief    : Shared ROB entry type, opcode constants and opcode decode helper.
// Revision : 1.0 - initial release
// ============================================================================
package reorder_buffer_n_pkg;

    localparam int C_PREG_W = 6;
    localparam int C_XLEN   = 32;

    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_LW = 7'b0000011;

    localparam logic [1:0] ROB_ALU = 2'd0;
    localparam logic [1:0] ROB_SW  = 2'd1;
    localparam logic [1:0] ROB_LW  = 2'd2;

    typedef struct packed {
        logic                v;
        logic                done;
        logic [1:0]          instr_type;
        logic [C_PREG_W-1:0] pd;
        logic [C_PREG_W-1:0] old_pd;
        logic [C_XLEN-1:0]   data;
    } rob_entry_t;

    function automatic logic [1:0] op_to_type(input logic [6:0] op);
        logic [1:0] t;
        t = ROB_ALU;
        if (op == OP_SW) begin
            t = ROB_SW;
        end else if (op == OP_LW) begin
            t = ROB_LW;
        end
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_n_if.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_n_if
// Brief    : Dispatch, writeback, retire and status bundle of the ROB.
// Revision : 1.0 - initial release
// ============================================================================
interface reorder_buffer_n_if #(
    parameter int DEPTH  = 16,
    parameter int DISP_W = 2,
    parameter int WB_W   = 3,
    parameter int RET_W  = 2,
    parameter int PREG_W = 6,
    parameter int XLEN   = 32
);
    localparam int C_TAG_W = $clog2(DEPTH);

    logic [DISP_W-1:0]         disp_valid_i;
    logic [DISP_W*PREG_W-1:0]  disp_pd_i;
    logic [DISP_W*PREG_W-1:0]  disp_old_pd_i;
    logic [DISP_W*7-1:0]       disp_op_i;
    logic                      disp_ready_o;
    logic [DISP_W*C_TAG_W-1:0] disp_tag_o;

    logic [WB_W-1:0]           wb_valid_i;
    logic [WB_W*C_TAG_W-1:0]   wb_tag_i;
    logic [WB_W*XLEN-1:0]      wb_data_i;

    logic [RET_W-1:0]          ret_valid_o;
    logic [RET_W*PREG_W-1:0]   ret_pd_o;
    logic [RET_W*PREG_W-1:0]   ret_old_pd_o;
    logic [RET_W*2-1:0]        ret_type_o;
    logic [RET_W*XLEN-1:0]     ret_data_o;

    logic                      flush_i;
    logic [C_TAG_W:0]          count_o;
    logic                      empty_o;
    logic                      full_o;
    logic [31:0]               retired_o;

    modport master (
        output disp_valid_i, disp_pd_i, disp_old_pd_i, disp_op_i,
        output wb_valid_i, wb_tag_i, wb_data_i, flush_i,
        input  disp_ready_o, disp_tag_o,
        input  ret_valid_o, ret_pd_o, ret_old_pd_o, ret_type_o, ret_data_o,
        input  count_o, empty_o, full_o, retired_o
    );

    modport slave (
        input  disp_valid_i, disp_pd_i, disp_old_pd_i, disp_op_i,
        input  wb_valid_i, wb_tag_i, wb_data_i, flush_i,
        output disp_ready_o, disp_tag_o,
        output ret_valid_o, ret_pd_o, ret_old_pd_o, ret_type_o, ret_data_o,
        output count_o, empty_o, full_o, retired_o
    );

endinterface
`default_nettype wire

// File: rtl/reorder_buffer_n_rob_ptr.sv
`default_nettype none
// ============================================================================
// Module   : rob_ptr
// Brief    : Circular pointer with wrap bit, advanced by up to MAXINC per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rob_ptr #(
    parameter int DEPTH  = 16,
    parameter int MAXINC = 2
) (
    input  wire                           clk,
    input  wire                           rst,
    input  wire [$clog2(MAXINC+1)-1:0]    inc,
    input  wire                           clear,
    output logic [$clog2(DEPTH):0]        ptr,
    output logic [$clog2(DEPTH)-1:0]      idx
);
    localparam int C_IDX_W = $clog2(DEPTH);
    localparam int C_PTR_W = C_IDX_W + 1;

    logic [C_PTR_W-1:0] r_ptr_q;
    logic [C_PTR_W-1:0] w_ptr_d;

    // DEPTH is a power of two, so plain binary wrap of the extra bit is the wrap flag.
    always_comb begin
        w_ptr_d = r_ptr_q + C_PTR_W'(inc);
        if (clear) begin
            w_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

    assign ptr = r_ptr_q;
    assign idx = r_ptr_q[C_IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/reorder_buffer_n.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_n
// Brief    : In-order allocate / tag-indexed complete / in-order retire ROB.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer_n
    import reorder_buffer_n_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DISP_W = 2,
    parameter int WB_W   = 3,
    parameter int RET_W  = 2,
    parameter int PREG_W = 6,
    parameter int XLEN   = 32
) (
    input  wire               clk,
    input  wire               rst,
    reorder_buffer_n_if.slave bus
);
    localparam int C_IDX_W  = $clog2(DEPTH);
    localparam int C_PTR_W  = C_IDX_W + 1;
    localparam int C_DCNT_W = $clog2(DISP_W + 1);
    localparam int C_RCNT_W = $clog2(RET_W + 1);

    // Entry storage uses the package struct, whose field widths are fixed.
    if (PREG_W != C_PREG_W || XLEN != C_XLEN) begin : g_width_check
        $error("reorder_buffer_n: PREG_W/XLEN must equal rob_entry_t field widths");
    end

    rob_entry_t r_rob_q [DEPTH];
    rob_entry_t w_rob_d [DEPTH];

    logic [C_PTR_W-1:0]  w_head_ptr, w_tail_ptr, w_count;
    logic [C_IDX_W-1:0]  w_head_idx, w_tail_idx;
    logic [C_DCNT_W-1:0] w_disp_cnt, w_tail_inc;
    logic [C_RCNT_W-1:0] w_ret_cnt, w_head_inc;
    logic                w_disp_ready, w_disp_accept, w_ret_stop;
    logic [RET_W-1:0]    w_ret_sel;
    logic [C_IDX_W-1:0]  w_ret_idx  [RET_W];
    logic [C_IDX_W-1:0]  w_disp_idx [DISP_W];

    logic [RET_W-1:0]        r_ret_valid_q,  w_ret_valid_d;
    logic [RET_W*PREG_W-1:0] r_ret_pd_q,     w_ret_pd_d;
    logic [RET_W*PREG_W-1:0] r_ret_old_pd_q, w_ret_old_pd_d;
    logic [RET_W*2-1:0]      r_ret_type_q,   w_ret_type_d;
    logic [RET_W*XLEN-1:0]   r_ret_data_q,   w_ret_data_d;
    logic [31:0]             r_retired_q,    w_retired_d;

    rob_ptr #(.DEPTH(DEPTH), .MAXINC(RET_W)) u_head_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_head_inc),
        .clear (bus.flush_i),
        .ptr   (w_head_ptr),
        .idx   (w_head_idx)
    );

    rob_ptr #(.DEPTH(DEPTH), .MAXINC(DISP_W)) u_tail_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_tail_inc),
        .clear (bus.flush_i),
        .ptr   (w_tail_ptr),
        .idx   (w_tail_idx)
    );

    // Readiness looks only at current occupancy, never at same-cycle retirement.
    assign w_count       = w_tail_ptr - w_head_ptr;
    assign w_disp_ready  = (C_PTR_W'(DEPTH) - w_count) >= C_PTR_W'(DISP_W);
    assign w_disp_accept = w_disp_ready && !bus.flush_i;

    always_comb begin
        w_disp_cnt = '0;
        for (int i = 0; i < DISP_W; i++) begin
            w_disp_cnt = w_disp_cnt + C_DCNT_W'(bus.disp_valid_i[i]);
        end
    end

    assign w_tail_inc = w_disp_accept ? w_disp_cnt : '0;
    assign w_head_inc = bus.flush_i ? '0 : w_ret_cnt;

    for (genvar gi = 0; gi < DISP_W; gi++) begin : g_disp_idx
        assign w_disp_idx[gi] = w_tail_idx + C_IDX_W'(gi);
        assign bus.disp_tag_o[gi*C_IDX_W +: C_IDX_W] = w_disp_idx[gi];
    end

    for (genvar gr = 0; gr < RET_W; gr++) begin : g_ret_idx
        assign w_ret_idx[gr] = w_head_idx + C_IDX_W'(gr);
    end

    always_comb begin
        w_ret_sel  = '0;
        w_ret_cnt  = '0;
        w_ret_stop = 1'b0;
        for (int i = 0; i < RET_W; i++) begin
            if (!w_ret_stop && r_rob_q[w_ret_idx[i]].v && r_rob_q[w_ret_idx[i]].done) begin
                w_ret_sel[i] = 1'b1;
                w_ret_cnt    = w_ret_cnt + C_RCNT_W'(1);
            end else begin
                w_ret_stop = 1'b1;
            end
        end
    end

    // Ascending port order lets the highest-indexed port win a tag collision.
    always_comb begin
        w_rob_d = r_rob_q;
        for (int p = 0; p < WB_W; p++) begin
            if (bus.wb_valid_i[p] && r_rob_q[bus.wb_tag_i[p*C_IDX_W +: C_IDX_W]].v) begin
                w_rob_d[bus.wb_tag_i[p*C_IDX_W +: C_IDX_W]].done = 1'b1;
                w_rob_d[bus.wb_tag_i[p*C_IDX_W +: C_IDX_W]].data = bus.wb_data_i[p*XLEN +: XLEN];
            end
        end
        for (int i = 0; i < RET_W; i++) begin
            if (w_ret_sel[i]) begin
                w_rob_d[w_ret_idx[i]] = '0;
            end
        end
        if (w_disp_accept) begin
            for (int i = 0; i < DISP_W; i++) begin
                if (bus.disp_valid_i[i]) begin
                    w_rob_d[w_disp_idx[i]].v          = 1'b1;
                    w_rob_d[w_disp_idx[i]].done       = 1'b0;
                    w_rob_d[w_disp_idx[i]].instr_type = op_to_type(bus.disp_op_i[i*7 +: 7]);
                    w_rob_d[w_disp_idx[i]].pd         = bus.disp_pd_i[i*PREG_W +: PREG_W];
                    w_rob_d[w_disp_idx[i]].old_pd     = bus.disp_old_pd_i[i*PREG_W +: PREG_W];
                    w_rob_d[w_disp_idx[i]].data       = '0;
                end
            end
        end
        if (bus.flush_i) begin
            for (int e = 0; e < DEPTH; e++) begin
                w_rob_d[e] = '0;
            end
        end
    end

    always_comb begin
        w_ret_valid_d  = '0;
        w_ret_pd_d     = '0;
        w_ret_old_pd_d = '0;
        w_ret_type_d   = '0;
        w_ret_data_d   = '0;
        w_retired_d    = r_retired_q;
        if (!bus.flush_i) begin
            w_ret_valid_d = w_ret_sel;
            for (int i = 0; i < RET_W; i++) begin
                if (w_ret_sel[i]) begin
                    w_ret_pd_d[i*PREG_W +: PREG_W]     = r_rob_q[w_ret_idx[i]].pd;
                    w_ret_old_pd_d[i*PREG_W +: PREG_W] = r_rob_q[w_ret_idx[i]].old_pd;
                    w_ret_type_d[i*2 +: 2]             = r_rob_q[w_ret_idx[i]].instr_type;
                    w_ret_data_d[i*XLEN +: XLEN]       = r_rob_q[w_ret_idx[i]].data;
                end
            end
            w_retired_d = r_retired_q + 32'(w_ret_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_rob_q[e] <= '0;
            end
            r_ret_valid_q  <= '0;
            r_ret_pd_q     <= '0;
            r_ret_old_pd_q <= '0;
            r_ret_type_q   <= '0;
            r_ret_data_q   <= '0;
            r_retired_q    <= '0;
        end else begin
            r_rob_q        <= w_rob_d;
            r_ret_valid_q  <= w_ret_valid_d;
            r_ret_pd_q     <= w_ret_pd_d;
            r_ret_old_pd_q <= w_ret_old_pd_d;
            r_ret_type_q   <= w_ret_type_d;
            r_ret_data_q   <= w_ret_data_d;
            r_retired_q    <= w_retired_d;
        end
    end

    assign bus.disp_ready_o = w_disp_ready;
    assign bus.ret_valid_o  = r_ret_valid_q;
    assign bus.ret_pd_o     = r_ret_pd_q;
    assign bus.ret_old_pd_o = r_ret_old_pd_q;
    assign bus.ret_type_o   = r_ret_type_q;
    assign bus.ret_data_o   = r_ret_data_q;
    assign bus.count_o      = w_count;
    assign bus.empty_o      = (w_head_ptr == w_tail_ptr);
    assign bus.full_o       = (w_head_idx == w_tail_idx) &&
                              (w_head_ptr[C_IDX_W] != w_tail_ptr[C_IDX_W]);
    assign bus.retired_o    = r_retired_q;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer_n
// Brief    : Directed scoreboard bench for reorder_buffer_n.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer_n;

    localparam int DEPTH  = 16;
    localparam int DISP_W = 2;
    localparam int WB_W   = 3;
    localparam int RET_W  = 2;
    localparam int PREG_W = 6;
    localparam int XLEN   = 32;

    localparam logic [6:0] C_OP_ALU = 7'b0110011;
    localparam logic [6:0] C_OP_SW  = 7'b0100011;
    localparam logic [6:0] C_OP_LW  = 7'b0000011;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reorder_buffer_n_if #(
        .DEPTH(DEPTH), .DISP_W(DISP_W), .WB_W(WB_W),
        .RET_W(RET_W), .PREG_W(PREG_W), .XLEN(XLEN)
    ) bus ();

    reorder_buffer_n #(
        .DEPTH(DEPTH), .DISP_W(DISP_W), .WB_W(WB_W),
        .RET_W(RET_W), .PREG_W(PREG_W), .XLEN(XLEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [5:0]  m_pd   [DEPTH];
    logic [5:0]  m_old  [DEPTH];
    logic [1:0]  m_type [DEPTH];
    logic [31:0] m_data [DEPTH];
    int          sb_q   [$];
    logic [31:0] m_retired;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [1:0] exp_type(input logic [6:0] op);
        if (op == 7'b0100011) return 2'd1;
        if (op == 7'b0000011) return 2'd2;
        return 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops one expected entry per valid retire slot, in slot order.
    task automatic mon();
        int pops;
        int t;
        pops = 0;
        for (int s = 0; s < RET_W; s++) begin
            if (bus.ret_valid_o[s] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk($sformatf("ret_unexpected_slot%0d", s), 1, 0);
                end else begin
                    t = sb_q.pop_front();
                    chk($sformatf("ret_slot%0d_tag%0d", s, t),
                        {bus.ret_pd_o[s*6 +: 6], bus.ret_old_pd_o[s*6 +: 6],
                         bus.ret_type_o[s*2 +: 2], bus.ret_data_o[s*32 +: 32]},
                        {m_pd[t], m_old[t], m_type[t], m_data[t]});
                end
                pops++;
            end
        end
        m_retired = m_retired + 32'(pops);
        chk("retired_o", bus.retired_o, m_retired);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic idle();
        bus.disp_valid_i  = '0;
        bus.disp_pd_i     = '0;
        bus.disp_old_pd_i = '0;
        bus.disp_op_i     = '0;
        bus.wb_valid_i    = '0;
        bus.wb_tag_i      = '0;
        bus.wb_data_i     = '0;
        bus.flush_i       = 1'b0;
    endtask

    task automatic record(input int t, input logic [5:0] pd, input logic [5:0] old, input logic [6:0] op);
        m_pd[t]   = pd;
        m_old[t]  = old;
        m_type[t] = exp_type(op);
        m_data[t] = '0;
        sb_q.push_back(t);
    endtask

    task automatic disp2(input int t0,
                         input logic [5:0] pd0, input logic [5:0] old0, input logic [6:0] op0,
                         input logic [5:0] pd1, input logic [5:0] old1, input logic [6:0] op1,
                         input bit accept);
        bus.disp_valid_i  = 2'b11;
        bus.disp_pd_i     = {pd1, pd0};
        bus.disp_old_pd_i = {old1, old0};
        bus.disp_op_i     = {op1, op0};
        if (accept) begin
            record(t0, pd0, old0, op0);
            record((t0 + 1) % DEPTH, pd1, old1, op1);
        end
    endtask

    task automatic wb(input int port, input int tag, input logic [31:0] data, input bit update);
        bus.wb_valid_i[port]         = 1'b1;
        bus.wb_tag_i[port*4 +: 4]    = 4'(tag);
        bus.wb_data_i[port*32 +: 32] = data;
        if (update) m_data[tag] = data;
    endtask

    initial begin
        rst = 1'b1;
        m_retired = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        chk("reset_count", bus.count_o, 5'd0);
        chk("reset_empty", bus.empty_o, 1'b1);
        chk("reset_full", bus.full_o, 1'b0);
        chk("reset_ready", bus.disp_ready_o, 1'b1);
        chk("reset_ret_valid", bus.ret_valid_o, 2'b00);
        chk("reset_ret_data", bus.ret_data_o, 64'd0);

        // In-order completion, two-cycle retire latency
        disp2(0, 6'd33, 6'd1, C_OP_ALU, 6'd34, 6'd2, C_OP_ALU, 1'b1);
        chk("t1_disp_tag", bus.disp_tag_o, 8'h10);
        tick(); idle();
        chk("t1_count", bus.count_o, 5'd2);
        wb(0, 0, 32'd5, 1'b1);
        wb(1, 1, 32'd7, 1'b1);
        tick(); idle();
        chk("t1_ret_n1", bus.ret_valid_o, 2'b00);
        tick();
        chk("t1_ret_n2", bus.ret_valid_o, 2'b11);
        chk("t1_ret_data", bus.ret_data_o, {32'd7, 32'd5});
        chk("t1_ret_old_pd", bus.ret_old_pd_o, {6'd2, 6'd1});
        tick();
        chk("t1_ret_pulse", bus.ret_valid_o, 2'b00);
        chk("t1_count_after", bus.count_o, 5'd0);

        // Out-of-order completion
        disp2(2, 6'd40, 6'd3, C_OP_ALU, 6'd41, 6'd4, C_OP_ALU, 1'b1);
        tick(); idle();
        wb(0, 3, 32'h33, 1'b1);
        tick(); idle();
        tick(); tick();
        chk("t2_no_retire", bus.ret_valid_o, 2'b00);
        chk("t2_count_held", bus.count_o, 5'd2);
        wb(1, 2, 32'h22, 1'b1);
        tick(); idle();
        chk("t2_ret_n1", bus.ret_valid_o, 2'b00);
        tick();
        chk("t2_both", bus.ret_valid_o, 2'b11);
        chk("t2_data_order", bus.ret_data_o, {32'h33, 32'h22});
        tick();

        // Store / load type decode
        disp2(4, 6'd10, 6'd11, C_OP_SW, 6'd12, 6'd13, C_OP_LW, 1'b1);
        tick(); idle();
        wb(2, 4, 32'h40, 1'b1);
        wb(1, 5, 32'h80, 1'b1);
        tick(); idle();
        tick();
        chk("t4_ret_valid", bus.ret_valid_o, 2'b11);
        chk("t4_ret_type", bus.ret_type_o, {2'd2, 2'd1});
        chk("t4_sw_addr", bus.ret_data_o[31:0], 32'h40);
        tick();

        // Fill to full, dropped dispatch, wrap of tags
        rst = 1'b1;
        m_retired = '0;
        sb_q.delete();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t3_ready_%0d", k), bus.disp_ready_o, 1'b1);
            disp2(2*k, 6'(20 + 2*k), 6'(2*k), C_OP_ALU, 6'(21 + 2*k), 6'(2*k + 1), C_OP_ALU, 1'b1);
            tick(); idle();
        end
        chk("t3_full", bus.full_o, 1'b1);
        chk("t3_not_ready", bus.disp_ready_o, 1'b0);
        chk("t3_count16", bus.count_o, 5'd16);
        disp2(0, 6'd50, 6'd50, C_OP_ALU, 6'd51, 6'd51, C_OP_ALU, 1'b0);
        chk("t3_tag_at_full", bus.disp_tag_o, 8'h10);
        tick(); idle();
        chk("t3_dropped_count", bus.count_o, 5'd16);
        chk("t3_tail_held", bus.disp_tag_o, 8'h10);
        wb(0, 0, 32'h100, 1'b1);
        wb(1, 1, 32'h101, 1'b1);
        tick(); idle();
        chk("t3_ready_before_retire", bus.disp_ready_o, 1'b0);
        tick();
        chk("t3_retire2", bus.ret_valid_o, 2'b11);
        chk("t3_count14", bus.count_o, 5'd14);
        chk("t3_ready_after", bus.disp_ready_o, 1'b1);
        chk("t3_wrap_tags", bus.disp_tag_o, 8'h10);

        // Flush of a nearly full buffer with a same-cycle writeback
        bus.flush_i = 1'b1;
        wb(0, 2, 32'h55, 1'b0);
        tick(); idle();
        sb_q.delete();
        chk("fa_count", bus.count_o, 5'd0);
        chk("fa_empty", bus.empty_o, 1'b1);
        chk("fa_ret_valid", bus.ret_valid_o, 2'b00);
        chk("fa_retired_held", bus.retired_o, 32'd2);

        // Same-tag writeback collision and writeback to an unallocated tag
        disp2(0, 6'd40, 6'd10, C_OP_ALU, 6'd41, 6'd11, C_OP_ALU, 1'b1); tick(); idle();
        disp2(2, 6'd42, 6'd12, C_OP_ALU, 6'd43, 6'd13, C_OP_SW,  1'b1); tick(); idle();
        disp2(4, 6'd44, 6'd14, C_OP_LW,  6'd45, 6'd15, C_OP_ALU, 1'b1); tick(); idle();
        chk("t6_count6", bus.count_o, 5'd6);
        wb(0, 3, 32'd8, 1'b0);
        wb(1, 12, 32'hdead, 1'b0);
        wb(2, 3, 32'd9, 1'b1);
        tick(); idle();
        chk("t6_count_unchanged", bus.count_o, 5'd6);
        wb(0, 0, 32'ha0, 1'b1);
        wb(1, 1, 32'ha1, 1'b1);
        wb(2, 2, 32'ha2, 1'b1);
        tick(); idle();
        chk("t6_ret_n1", bus.ret_valid_o, 2'b00);
        tick();
        chk("t6_ret_01", bus.ret_valid_o, 2'b11);
        tick();
        chk("t6_ret_23", bus.ret_valid_o, 2'b11);
        chk("t6_tag3_high_port", bus.ret_data_o[63:32], 32'd9);
        tick();
        chk("t6_ret_idle", bus.ret_valid_o, 2'b00);
        chk("t6_count2", bus.count_o, 5'd2);

        // Flush with six live entries and a same-cycle writeback
        disp2(6, 6'd46, 6'd16, C_OP_ALU, 6'd47, 6'd17, C_OP_ALU, 1'b1); tick(); idle();
        disp2(8, 6'd48, 6'd18, C_OP_ALU, 6'd49, 6'd19, C_OP_ALU, 1'b1); tick(); idle();
        chk("t5_count6", bus.count_o, 5'd6);
        bus.flush_i = 1'b1;
        wb(1, 4, 32'h77, 1'b0);
        tick(); idle();
        sb_q.delete();
        chk("t5_count", bus.count_o, 5'd0);
        chk("t5_empty", bus.empty_o, 1'b1);
        chk("t5_ret_valid", bus.ret_valid_o, 2'b00);
        chk("t5_retired_held", bus.retired_o, 32'd6);
        tick();
        chk("t5_ret_valid_next", bus.ret_valid_o, 2'b00);
        disp2(0, 6'd60, 6'd30, C_OP_LW, 6'd61, 6'd31, C_OP_ALU, 1'b1);
        chk("t5_tags_restart", bus.disp_tag_o, 8'h10);
        tick(); idle();
        wb(0, 0, 32'h1234, 1'b1);
        wb(1, 1, 32'h5678, 1'b1);
        tick(); idle();
        tick();
        chk("t5_ret_after_flush", bus.ret_valid_o, 2'b11);
        tick();
        chk("t5_final_count", bus.count_o, 5'd0);
        chk("t5_scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
